ctrl_link_tx: RTL and testbench



---
 rtl/ctrl_link_pkg.sv | 29 ++
 rtl/baud_tick_gen.sv | 28 ++
 rtl/ctrl_link_tx.sv | 127 ++++++++++++
 tb/tb_ctrl_link_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_link_pkg.sv
// Shared definitions for the player-2 controller serial link (transmitter and receiver).
// Frame layout: start, five data bits LSB first, even parity, stop.
package ctrl_link_pkg;

  localparam int   FRAME_BITS = 8;
  localparam int   DATA_BITS  = 5;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } link_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Reloadable down-counter: tick is high while the count sits at zero, marking the
// last clock of a bit period. Shared by the link transmitter and receiver.
module baud_tick_gen #(
  parameter  int DIV   = 1000,
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator runs processes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(DIV - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/ctrl_link_tx.sv
// Serialising transmitter for the player-2 controller link: snapshots the synchronised
// buttons and sends them as a parity-protected frame, back-to-back while enabled.
module ctrl_link_tx
  import ctrl_link_pkg::*;
#(
  parameter int BAUD_DIV = 1000,
  parameter int GAP_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] btn,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [DATA_BITS-1:0] sent_data
);

  localparam int TIMER_W  = $clog2(BAUD_DIV);
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam int GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  link_state_e          state, state_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [GAP_W-1:0]     gap_cnt, gap_next;
  logic [TIMER_W-1:0]   timer;
  logic                 tick, load;
  logic                 parity_reg;
  logic                 tx_next, busy_next, frame_done_next;
  logic [DATA_BITS-1:0] btn_meta, btn_sync;

  baud_tick_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .count (timer),
    .tick  (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    gap_next     = gap_cnt;
    load         = 1'b0;

    case (state)
      ST_IDLE: if (enable) begin
        state_next = ST_START;
        load       = 1'b1;
      end
      ST_START: if (tick) begin
        state_next   = ST_DATA;
        bit_idx_next = '0;
        load         = 1'b1;
      end
      ST_DATA: if (tick) begin
        load = 1'b1;
        if (bit_idx == IDX_W'(DATA_BITS - 1)) state_next = ST_PARITY;
        else                                  bit_idx_next = bit_idx + 1'b1;
      end
      ST_PARITY: if (tick) begin
        state_next = ST_STOP;
        load       = 1'b1;
      end
      ST_STOP: if (tick) begin
        if (GAP_BITS > 0) begin
          state_next = ST_GAP;
          gap_next   = GAP_W'(GAP_LAST);
          load       = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: if (tick) begin
        if (gap_cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_cnt - 1'b1;
          load     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are registered, so their next values follow the next state.
    case (state_next)
      ST_START:  tx_next = START_LVL;
      ST_DATA:   tx_next = sent_data[bit_idx_next];
      ST_PARITY: tx_next = parity_reg;
      default:   tx_next = STOP_LVL;
    endcase
    busy_next       = (state_next != ST_IDLE);
    frame_done_next = (state == ST_STOP) && (timer == TIMER_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sent_data  <= '0;
      parity_reg <= 1'b0;
      btn_meta   <= '0;
      btn_sync   <= '0;
    end else begin
      btn_meta   <= btn;
      btn_sync   <= btn_meta;
      state      <= state_next;
      bit_idx    <= bit_idx_next;
      gap_cnt    <= gap_next;
      tx         <= tx_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
      if (state == ST_IDLE && enable) begin
        sent_data  <= btn_sync;
        parity_reg <= even_parity(btn_sync);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_link_tx.sv
// Self-checking bench for ctrl_link_tx: a frame-offset reference model predicts
// tx/busy/frame_done/sent_data every cycle; directed checks cover timing corners.
module tb_ctrl_link_tx;

  localparam int BD  = 4;
  localparam int GAP = 2;
  localparam int LEN = (8 + GAP) * BD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] btn = 5'b0;
  logic       tx, busy, frame_done;
  logic [4:0] sent_data;
  logic       tx2, busy2, frame_done2;
  logic [4:0] sent_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  ctrl_link_tx #(.BAUD_DIV(BD), .GAP_BITS(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .btn(btn),
    .tx(tx), .busy(busy), .frame_done(frame_done), .sent_data(sent_data)
  );

  ctrl_link_tx #(.BAUD_DIV(BD), .GAP_BITS(0)) dut_nogap (
    .clk(clk), .reset(reset), .enable(enable), .btn(btn),
    .tx(tx2), .busy(busy2), .frame_done(frame_done2), .sent_data(sent_data2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: position within the current frame (0 = idle) and its snapshot.
  int         m_off;
  logic [4:0] m_snap, m_meta, m_sync;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_off  <= 0;
      m_snap <= '0;
      m_meta <= '0;
      m_sync <= '0;
    end else begin
      m_meta <= btn;
      m_sync <= m_meta;
      if (m_off == 0) begin
        if (enable) begin
          m_off  <= 1;
          m_snap <= m_sync;
        end
      end else if (m_off == LEN) begin
        m_off <= 0;
      end else begin
        m_off <= m_off + 1;
      end
    end
  end

  function automatic logic [7:0] exp_vec(input int off, input logic [4:0] snap);
    int   b;
    logic t;
    if (off == 0) return {1'b1, 1'b0, 1'b0, snap};
    b = (off - 1) / BD;
    if (b == 0)      t = 1'b0;
    else if (b <= 5) t = snap[b-1];
    else if (b == 6) t = ^snap;
    else             t = 1'b1;
    return {t, 1'b1, (off == 8 * BD), snap};
  endfunction

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {24'b0, tx, busy, frame_done, sent_data}, {24'b0, exp_vec(m_off, m_snap)});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rise(input bit sel, output int c);
    bit prev, cur;
    prev = sel ? busy2 : busy;
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cur = sel ? busy2 : busy;
      if (cur && !prev) begin
        c = cyc;
        return;
      end
      prev = cur;
    end
    check("timeout_rise", 32'd0, 32'd1);
  endtask

  task automatic wait_fall(output int c);
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        c = cyc;
        return;
      end
    end
    check("timeout_fall", 32'd0, 32'd1);
  endtask

  task automatic wait_fd(output int c);
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin
        c = cyc;
        return;
      end
    end
    check("timeout_fd", 32'd0, 32'd1);
  endtask

  initial begin
    int a, b, n, seen;

    // Reset held low with enable high: outputs stay at reset values.
    #1 reset = 1'b0;
    enable = 1'b1;
    btn    = 5'b10101;
    chk_en = 1'b1;
    step(10);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_data, 0);

    // First frame after reset with btn = 10110.
    enable = 1'b0;
    reset  = 1'b1;
    btn    = 5'b10110;
    step(4);
    enable = 1'b1;
    wait_rise(1'b0, a);
    wait_fd(b);
    check("fd_offset", b - a, 31);
    check("first_data", sent_data, 5'b10110);

    // Back-to-back frame spacing, with and without a gap.
    wait_rise(1'b0, a);
    wait_rise(1'b0, b);
    check("period", b - a, 41);
    wait_rise(1'b1, a);
    wait_rise(1'b1, b);
    check("period_nogap", b - a, 33);

    // Snapshot: change btn during DATA bit 2 of a frame carrying 00001.
    btn = 5'b00001;
    wait_rise(1'b0, a);
    wait_rise(1'b0, a);
    repeat (13) @(posedge clk);
    #2 btn = 5'b11111;
    wait_fd(b);
    check("snap_cur", sent_data, 5'b00001);
    wait_rise(1'b0, a);
    wait_fd(b);
    check("snap_next", sent_data, 5'b11111);

    // Randomised buttons and enable, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      step(1);
      if ($urandom_range(0, 7) == 0)  btn = 5'($urandom);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
    end
    enable = 1'b1;

    // Enable dropped during PARITY: frame and gap complete, nothing restarts.
    wait_rise(1'b0, a);
    repeat (26) @(posedge clk);
    #2 enable = 1'b0;
    wait_fall(b);
    check("drop_len", b - a, 40);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || !tx) seen++;
    end
    check("no_restart", seen, 0);

    // Reset pulsed during DATA bit 3 (a zero bit): tx returns high without a clock.
    btn = 5'b00111;
    step(4);
    enable = 1'b1;
    wait_rise(1'b0, a);
    repeat (17) @(posedge clk);
    #2 check("tx_d3", tx, 0);
    reset = 1'b0;
    #1 check("tx_async", tx, 1);
    check("busy_async", busy, 0);
    enable = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    enable = 1'b1;
    wait_rise(1'b0, a);
    n = (tx == 1'b0) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx == 1'b0) n++;
      else break;
    end
    check("start_len", n, 4);
    wait_fd(b);
    check("resume_data", sent_data, 5'b00111);

    step(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
